instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Two-byte instruction fetch/decode controller feeding a valid/ready ALU stage.
// Optional FETCH_ILLEGAL_HALT_EN: illegal opcodes halt instead of being skipped as NOPs.
module instr_fetch_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              sto_n,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [2:0]        op_code,
  output logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              halt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_OP  = 3'd1,
    S_FETCH_ARG = 3'd2,
    S_ISSUE     = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_STO = 3'd5;

  // Returns {legal, op_code} for an opcode byte.
  function automatic logic [3:0] decode_op(input logic [DATA_W-1:0] b);
    logic [3:0] r;
    r = 4'b0000;
    case (b)
      DATA_W'(8'h10): r = {1'b1, OP_LD};
      DATA_W'(8'h11): r = {1'b1, OP_ADD};
      DATA_W'(8'h12): r = {1'b1, OP_SUB};
      DATA_W'(8'h13): r = {1'b1, OP_AND};
      DATA_W'(8'h14): r = {1'b1, OP_OR};
      DATA_W'(8'h05): r = {1'b1, OP_STO};
      default:        r = 4'b0000;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [2:0]        op_code_q, op_code_d;
  logic              skip_q, skip_d;
  logic              op_valid_q, op_valid_d;
  logic              halt_q, halt_d;

  logic [3:0]        dec_s;
  logic              handshake_s;
  logic              store_s;

  assign dec_s = decode_op(mem_data);

  // Next-state and register update logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    operand_d  = operand_q;
    op_code_d  = op_code_q;
    skip_d     = skip_q;
    op_valid_d = op_valid_q;
    halt_d     = halt_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH_OP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_OP: begin
        pc_d = pc_q + ADDR_W'(1);
        if (dec_s[3]) begin
          op_code_d = dec_s[2:0];
          skip_d    = 1'b0;
          state_d   = S_FETCH_ARG;
        end else begin
`ifdef FETCH_ILLEGAL_HALT_EN
          halt_d  = 1'b1;
          state_d = S_HALT;
`else
          // Illegal opcode acts as a NOP: its operand byte is fetched but dropped.
          skip_d  = 1'b1;
          state_d = S_FETCH_ARG;
`endif
        end
      end
      S_FETCH_ARG: begin
        pc_d = pc_q + ADDR_W'(1);
        if (skip_q) begin
          skip_d  = 1'b0;
          state_d = S_FETCH_OP;
        end else begin
          operand_d  = mem_data;
          op_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = S_FETCH_OP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d    = S_IDLE;
        op_valid_d = 1'b0;
        halt_d     = 1'b0;
        skip_d     = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      operand_q  <= '0;
      op_code_q  <= 3'd0;
      skip_q     <= 1'b0;
      op_valid_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      operand_q  <= operand_d;
      op_code_q  <= op_code_d;
      skip_q     <= skip_d;
      op_valid_q <= op_valid_d;
      halt_q     <= halt_d;
    end
  end

  // Store strobe and address redirect exist only in the STO handshake cycle, never under reset.
  assign handshake_s = (state_q == S_ISSUE) && op_ready;
  assign store_s     = handshake_s && (op_code_q == OP_STO) && !rst;

  assign mem_addr = store_s ? operand_q[ADDR_W-1:0] : pc_q;
  assign sto_n    = ~store_s;
  assign op_valid = op_valid_q;
  assign op_code  = op_code_q;
  assign operand  = operand_q;
  assign pc       = pc_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: vector table, directed corner sequences,
// and randomized programs checked against an instruction-level reference model.
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, op_ready;
  logic [3:0] mem_addr, pc;
  logic [7:0] mem_data, operand;
  logic       sto_n, op_valid, halt;
  logic [2:0] op_code;
  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  assign mem_data = mem[mem_addr];

  instr_fetch_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_data(mem_data),
    .sto_n(sto_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .operand(operand), .pc(pc), .halt(halt)
  );

  typedef struct {
    logic [7:0] opc;
    logic [7:0] arg;
    logic       exp_valid;
    logic [2:0] exp_code;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] legal_b [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h05};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic adv();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) adv();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; op_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Run pulse in cycle 0, leaves the bench at the start of cycle 1.
  task automatic start_run();
    run = 1'b1; cyc = 0;
    adv();
    run = 1'b0;
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i += 2) begin
      mem[i] = 8'h10; mem[i+1] = 8'h00;
    end
  endtask

  // Instruction-level model: returns next legal instruction starting at mp, advancing mp.
  task automatic model_next(inout logic [3:0] mp, output logic [2:0] code, output logic [7:0] arg);
    int idx;
    code = 3'd0; arg = 8'h00;
    for (int n = 0; n < 8; n++) begin
      idx = -1;
      for (int j = 0; j < 6; j++) if (legal_b[j] == mem[mp]) idx = j;
      arg = mem[mp + 4'd1];
      mp  = mp + 4'd2;
      if (idx >= 0) begin
        code = 3'(idx);
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] s_operand;
    logic [2:0] s_code;
    logic [3:0] mp;
    logic [2:0] m_code;
    logic [7:0] m_arg;
    int hs, last_hs;

    vecs[0] = '{8'h10, 8'h05, 1'b1, 3'd0};
    vecs[1] = '{8'h11, 8'h7E, 1'b1, 3'd1};
    vecs[2] = '{8'h12, 8'h00, 1'b1, 3'd2};
    vecs[3] = '{8'h13, 8'hFF, 1'b1, 3'd3};
    vecs[4] = '{8'h14, 8'h5A, 1'b1, 3'd4};
    vecs[5] = '{8'h05, 8'h0C, 1'b1, 3'd5};
    vecs[6] = '{8'hFF, 8'h11, 1'b0, 3'd0};
    vecs[7] = '{8'h15, 8'h22, 1'b0, 3'd0};
    vecs[8] = '{8'h00, 8'h10, 1'b0, 3'd0};

    // Reset state
    load_default();
    do_reset();
    smp();
    chk("rst_pc", pc, 0); chk("rst_valid", op_valid, 0); chk("rst_sto_n", sto_n, 1);
    chk("rst_halt", halt, 0); chk("rst_code", op_code, 0); chk("rst_operand", operand, 0);
    adv(); smp();
    chk("idle_hold_pc", pc, 0); chk("idle_hold_valid", op_valid, 0);

    // Decode table: first instruction observed in cycle 3
    for (int v = 0; v < 9; v++) begin
      load_default();
      mem[0] = vecs[v].opc; mem[1] = vecs[v].arg;
      do_reset(); start_run();
      to_cyc(3); smp();
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d_valid", v), op_valid, 1);
        chk($sformatf("vec%0d_code", v), op_code, vecs[v].exp_code);
        chk($sformatf("vec%0d_operand", v), operand, vecs[v].arg);
        chk($sformatf("vec%0d_pc", v), pc, 2);
      end else begin
`ifdef FETCH_ILLEGAL_HALT_EN
        chk($sformatf("vec%0d_halt", v), halt, 1);
        chk($sformatf("vec%0d_pc", v), pc, 1);
`else
        chk($sformatf("vec%0d_valid", v), op_valid, 0);
        chk($sformatf("vec%0d_pc", v), pc, 2);
`endif
      end
      chk($sformatf("vec%0d_sto_n", v), sto_n, 1);
    end

    // LD 0x05 with op_ready high: valid in cycle 3
    load_default(); mem[0] = 8'h10; mem[1] = 8'h05;
    do_reset(); op_ready = 1'b1; start_run();
    to_cyc(2); smp(); chk("ld_c2_valid", op_valid, 0);
    to_cyc(3); smp();
    chk("ld_valid", op_valid, 1); chk("ld_code", op_code, 0);
    chk("ld_operand", operand, 8'h05); chk("ld_pc", pc, 2);

    // Backpressure: four stalled cycles hold everything
    load_default(); mem[0] = 8'h12; mem[1] = 8'hA5;
    do_reset(); start_run();
    to_cyc(3); smp();
    s_code = op_code; s_operand = operand;
    chk("bp_code", s_code, 2); chk("bp_operand", s_operand, 8'hA5);
    for (int k = 3; k < 7; k++) begin
      to_cyc(k); smp();
      chk("bp_hold_valid", op_valid, 1); chk("bp_hold_code", op_code, s_code);
      chk("bp_hold_operand", operand, s_operand); chk("bp_hold_pc", pc, 2);
      chk("bp_hold_addr", mem_addr, 2);
    end
    to_cyc(7); op_ready = 1'b1; smp();
    chk("bp_hs_valid", op_valid, 1); chk("bp_hs_sto_n", sto_n, 1);
    to_cyc(8); smp();
    chk("bp_after_valid", op_valid, 0); chk("bp_after_addr", mem_addr, 2);

    // STO 0x05: single-cycle strobe addressed by operand
    load_default(); mem[0] = 8'h05; mem[1] = 8'h05;
    do_reset(); op_ready = 1'b1; start_run();
    to_cyc(2); smp(); chk("sto_pre_sto_n", sto_n, 1);
    to_cyc(3); smp();
    chk("sto_strobe", sto_n, 0); chk("sto_addr", mem_addr, 5); chk("sto_code", op_code, 5);
    to_cyc(4); smp();
    chk("sto_post_sto_n", sto_n, 1); chk("sto_post_addr", mem_addr, 2);
    to_cyc(6); smp(); chk("sto_next_ld_sto_n", sto_n, 1); chk("sto_next_ld_valid", op_valid, 1);

    // Eight instructions wrap pc back to 0
    for (int i = 0; i < 8; i++) begin
      mem[2*i] = 8'h11; mem[2*i+1] = 8'(i);
    end
    do_reset(); op_ready = 1'b1; start_run();
    to_cyc(24); smp();
    chk("wrap_valid", op_valid, 1); chk("wrap_operand", operand, 7); chk("wrap_pc", pc, 0);
    to_cyc(25); smp();
    chk("wrap_fetch_valid", op_valid, 0); chk("wrap_fetch_addr", mem_addr, 0);
    to_cyc(27); smp();
    chk("wrap_reissue_operand", operand, 0); chk("wrap_reissue_pc", pc, 2);

    // Illegal opcode at pc=4
    load_default(); mem[4] = 8'hFF; mem[5] = 8'h33;
    do_reset(); op_ready = 1'b1; start_run();
    to_cyc(7); smp(); chk("ill_c7_valid", op_valid, 0); chk("ill_c7_addr", mem_addr, 4);
`ifdef FETCH_ILLEGAL_HALT_EN
    to_cyc(8); smp(); chk("ill_halt", halt, 1); chk("ill_halt_pc", pc, 5);
    to_cyc(9); run = 1'b1;
    to_cyc(12); smp();
    chk("ill_halt_hold", halt, 1); chk("ill_halt_hold_pc", pc, 5);
    chk("ill_halt_valid", op_valid, 0); chk("ill_halt_addr", mem_addr, 5);
    run = 1'b0;
`else
    to_cyc(8); smp(); chk("ill_c8_valid", op_valid, 0); chk("ill_c8_pc", pc, 5);
    to_cyc(9); smp(); chk("ill_c9_valid", op_valid, 0); chk("ill_c9_pc", pc, 6);
    chk("ill_halt", halt, 0);
    to_cyc(11); smp(); chk("ill_next_valid", op_valid, 1); chk("ill_next_pc", pc, 8);
`endif

    // Reset during STO handshake: no strobe, back to IDLE
    load_default(); mem[0] = 8'h05; mem[1] = 8'h09;
    do_reset(); start_run();
    to_cyc(3); op_ready = 1'b1; rst = 1'b1; smp();
    chk("rstsb_sto_n", sto_n, 1); chk("rstsb_addr", mem_addr, 2);
    to_cyc(4); rst = 1'b0; smp();
    chk("rstsb_pc", pc, 0); chk("rstsb_valid", op_valid, 0); chk("rstsb_sto_n2", sto_n, 1);
    chk("rstsb_halt", halt, 0); chk("rstsb_operand", operand, 0);
    to_cyc(6); smp();
    chk("rstsb_idle_pc", pc, 0); chk("rstsb_idle_addr", mem_addr, 0); chk("rstsb_idle_valid", op_valid, 0);

    // Randomized programs against the instruction-level model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i += 2) begin
`ifdef FETCH_ILLEGAL_HALT_EN
        mem[i] = legal_b[$urandom_range(0, 5)];
`else
        mem[i] = ($urandom_range(0, 4) != 0) ? legal_b[$urandom_range(0, 5)] : 8'($urandom);
`endif
        mem[i+1] = 8'($urandom);
      end
      mem[0] = legal_b[$urandom_range(0, 5)];
      do_reset(); start_run();
      mp = 4'd0; hs = 0; last_hs = 0;
      for (int k = 1; k < 400; k++) begin
        to_cyc(k);
        op_ready = ($urandom_range(0, 3) != 0);
        run = 1'($urandom);
        smp();
        if (op_valid && op_ready) begin
          model_next(mp, m_code, m_arg);
          chk("rnd_code", op_code, m_code);
          chk("rnd_operand", operand, m_arg);
          chk("rnd_pc", pc, mp);
          chk("rnd_sto_n", sto_n, (m_code == 3'd5) ? 1'b0 : 1'b1);
          if (m_code == 3'd5) chk("rnd_sto_addr", mem_addr, m_arg[3:0]);
          chk("rnd_gap", (cyc - last_hs) >= 3, 1);
          last_hs = cyc; hs++;
        end else begin
          chk("rnd_idle_sto_n", sto_n, 1);
          if (op_valid) chk("rnd_stall_addr", mem_addr, pc);
        end
      end
      run = 1'b0;
      chk("rnd_progress", hs >= 20, 1);
      chk("rnd_halt", halt, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
